// File: rtl/gate_selftest_seq.sv
// gate_selftest_seq: built-in self-test sequencer for a downstream two-input
// gate block. Sweeps {a,b} through 00,01,10,11 PASSES times, holds each vector
// SETTLE_CYC cycles, samples the seven gate results once per vector and
// records a saturating mismatch count, the first failing vector and a verdict.
module gate_selftest_seq #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned PASSES     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic       fail_valid,
    output logic [1:0] fail_ab
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] pidx_q, pidx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       fv_q, fv_d;
    logic [1:0] fab_q, fab_d;
    logic       mismatch;

    // Golden results {and,or,not_a,nand,nor,xor,xnor} for a vector {a,b}.
    function automatic logic [6:0] expected_gates(input logic [1:0] v);
        logic [6:0] r;
        case (v)
            2'b00:   r = 7'b0011101;
            2'b01:   r = 7'b0111010;
            2'b10:   r = 7'b0101010;
            default: r = 7'b1100001;
        endcase
        return r;
    endfunction

    // State and result registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pidx_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fv_q    <= 1'b0;
            fab_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            fab_q   <= fab_d;
        end
    end

    // Next-state logic: sweep sequencing, sampling and result bookkeeping.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        pidx_d   = pidx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pass_d   = pass_q;
        fv_d     = fv_q;
        fab_d    = fab_q;
        mismatch = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    pidx_d  = '0;
                    cnt_d   = SETTLE_LD;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fv_d    = 1'b0;
                    fab_d   = '0;
                end
            end

            SETTLE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SAMPLE: begin
                mismatch = (gate_in != expected_gates(vec_q));
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 8'd1;
                    end
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        fab_d = vec_q;
                    end
                end
                // Verdict is latched on the way into DONE so it already
                // reflects this final sample.
                if (vec_q == 2'b11 && pidx_q == PASS_LAST) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = SETTLE_LD;
                    if (vec_q == 2'b11) begin
                        pidx_d = pidx_q + 8'd1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        a          = (state_q == IDLE) ? 1'b0 : vec_q[1];
        b          = (state_q == IDLE) ? 1'b0 : vec_q[0];
        pass       = pass_q;
        err_cnt    = err_q;
        fail_valid = fv_q;
        fail_ab    = fab_q;
    end

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Self-checking bench for gate_selftest_seq. Three instances cover the default
// geometry, a multi-pass/long-settle geometry and a 255-pass saturation run.
// The reference model derives the expected vector, sample points and result
// registers from cycle arithmetic and a boolean gate model.
module tb_gate_selftest_seq;

    logic       clk;
    logic       rst_v   [3];
    logic       start_v [3];
    logic [6:0] gin_v   [3];
    logic       a_w     [3];
    logic       b_w     [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic [7:0] ec_w    [3];
    logic       fv_w    [3];
    logic [1:0] fab_w   [3];

    int checks = 0;
    int errors = 0;

    gate_selftest_seq u_def (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_w[0]), .b(b_w[0]),
        .gate_in(gin_v[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_cnt(ec_w[0]), .fail_valid(fv_w[0]), .fail_ab(fab_w[0])
    );

    gate_selftest_seq #(.SETTLE_CYC(4), .PASSES(3)) u_p3 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_w[1]), .b(b_w[1]),
        .gate_in(gin_v[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_cnt(ec_w[1]), .fail_valid(fv_w[1]), .fail_ab(fab_w[1])
    );

    gate_selftest_seq #(.SETTLE_CYC(1), .PASSES(255)) u_p255 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_w[2]), .b(b_w[2]),
        .gate_in(gin_v[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_cnt(ec_w[2]), .fail_valid(fv_w[2]), .fail_ab(fab_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate block: {and,or,not_a,nand,nor,xor,xnor}.
    function automatic logic [6:0] gate_model(input logic x, input logic y);
        return {x & y, x | y, ~x, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_results(input int inst, input string pfx, input int pass_e,
                               input int err_e, input int fv_e, input int fab_e);
        chk({pfx, "_pass"}, 32'(pass_w[inst]), 32'(pass_e));
        chk({pfx, "_err"}, 32'(ec_w[inst]), 32'(err_e));
        chk({pfx, "_fv"}, 32'(fv_w[inst]), 32'(fv_e));
        chk({pfx, "_fab"}, 32'(fab_w[inst]), 32'(fab_e));
    endtask

    task automatic chk_idle(input int inst, input string pfx);
        chk({pfx, "_busy"}, 32'(busy_w[inst]), 32'(0));
        chk({pfx, "_done"}, 32'(done_w[inst]), 32'(0));
        chk({pfx, "_ab"}, 32'({a_w[inst], b_w[inst]}), 32'(0));
    endtask

    // Full run. Entered just after an edge with the DUT in IDLE; returns in
    // the IDLE cycle following DONE. mode: 0 good, 1 stuck-at-0 bits in mask,
    // 2 all zero, 3 all inverted, other random corruption.
    task automatic do_run(input int inst, input int np, input int ns, input int mode,
                          input logic [6:0] mask, input bit start_noise, input bit hold_start,
                          output int m_err, output int m_fv, output int m_fab);
        int total;
        int errs;
        int fv;
        int fab;
        logic [1:0] vv;
        logic [6:0] good;
        logic [6:0] g;
        total = np * 4 * (ns + 1);
        errs = 0;
        fv = 0;
        fab = 0;
        start_v[inst] = 1'b1;
        gin_v[inst] = 7'($urandom);
        tick();
        for (int c = 0; c < total; c++) begin
            vv = 2'((c / (ns + 1)) % 4);
            chk("run_busy", 32'(busy_w[inst]), 32'(1));
            chk("run_done", 32'(done_w[inst]), 32'(0));
            chk("run_ab", 32'({a_w[inst], b_w[inst]}), 32'(vv));
            start_v[inst] = hold_start ? 1'b1 : (start_noise ? 1'($urandom) : 1'b0);
            if (c % (ns + 1) == ns) begin
                good = gate_model(vv[1], vv[0]);
                case (mode)
                    0: g = good;
                    1: g = good & ~mask;
                    2: g = '0;
                    3: g = ~good;
                    default: g = ($urandom % 4 == 0) ? 7'($urandom) : good;
                endcase
                gin_v[inst] = g;
                if (g !== good) begin
                    errs++;
                    if (fv == 0) begin
                        fv = 1;
                        fab = int'(vv);
                    end
                end
            end else begin
                gin_v[inst] = 7'($urandom);
            end
            tick();
        end
        m_err = (errs > 255) ? 255 : errs;
        m_fv = fv;
        m_fab = fab;
        chk("done_busy", 32'(busy_w[inst]), 32'(1));
        chk("done_pulse", 32'(done_w[inst]), 32'(1));
        chk("done_ab", 32'({a_w[inst], b_w[inst]}), 32'(3));
        chk_results(inst, "done", (errs == 0) ? 1 : 0, m_err, fv, fab);
        start_v[inst] = (hold_start || start_noise) ? 1'b1 : 1'b0;
        gin_v[inst] = 7'($urandom);
        tick();
        chk_idle(inst, "post");
        chk_results(inst, "post", (errs == 0) ? 1 : 0, m_err, fv, fab);
        start_v[inst] = hold_start ? 1'b1 : 1'b0;
    endtask

    // Starts a run on the default instance with every sample failing, then
    // asserts rst (together with start) on the first cycle of vector 10.
    task automatic do_abort();
        int ns;
        ns = 1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 0; c < 2 * (ns + 1); c++) begin
            chk("abort_ab", 32'({a_w[0], b_w[0]}), 32'((c / (ns + 1)) % 4));
            gin_v[0] = (c % (ns + 1) == ns) ? 7'd0 : 7'($urandom);
            tick();
        end
        chk("abort_at10_ab", 32'({a_w[0], b_w[0]}), 32'(2));
        chk_results(0, "abort_pre", 0, 2, 1, 0);
        rst_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        chk_idle(0, "abort_rst");
        chk_results(0, "abort_rst", 0, 0, 0, 0);
        tick();
        chk_idle(0, "abort_rst2");
        rst_v[0] = 1'b0;
        start_v[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gin_v[0] = 7'($urandom);
            tick();
            chk("abort_nodone", 32'(done_w[0]), 32'(0));
            chk("abort_idle", 32'(busy_w[0]), 32'(0));
        end
    endtask

    int me, mf, mb;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            start_v[i] = 1'b1;
            gin_v[i] = 7'($urandom);
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_idle(i, "reset");
            chk_results(i, "reset", 0, 0, 0, 0);
            rst_v[i] = 1'b0;
            start_v[i] = 1'b0;
        end
        tick();
        chk_idle(0, "reset_release");

        // Correct gate block, defaults: done 8 cycles after start.
        do_run(0, 1, 1, 0, 7'd0, 1'b0, 1'b0, me, mf, mb);
        chk_results(0, "good", 1, 0, 0, 0);

        // Idle with garbage on gate_in: results must hold.
        for (int i = 0; i < 4; i++) begin
            gin_v[0] = 7'($urandom);
            tick();
        end
        chk_idle(0, "hold");
        chk_results(0, "hold", 1, 0, 0, 0);

        // xor stuck at 0: mismatches only at 01 and 10.
        do_run(0, 1, 1, 1, 7'b0000010, 1'b0, 1'b0, me, mf, mb);
        chk_results(0, "xor_sa0", 0, 2, 1, 1);

        // Randomised corruption with start toggling during the run.
        for (int r = 0; r < 8; r++) begin
            do_run(0, 1, 1, 4, 7'd0, 1'b1, 1'b0, me, mf, mb);
            tick();
        end

        // Start held high: back-to-back runs separated by one IDLE cycle.
        do_run(0, 1, 1, 0, 7'd0, 1'b0, 1'b1, me, mf, mb);
        do_run(0, 1, 1, 3, 7'd0, 1'b0, 1'b1, me, mf, mb);
        do_run(0, 1, 1, 0, 7'd0, 1'b0, 1'b0, me, mf, mb);
        chk_results(0, "hold_start", 1, 0, 0, 0);

        // Mid-run reset, then a fresh run.
        do_abort();
        do_run(0, 1, 1, 0, 7'd0, 1'b0, 1'b0, me, mf, mb);
        chk_results(0, "after_abort", 1, 0, 0, 0);

        // Three passes, 4-cycle settle, gate_in forced to 0.
        do_run(1, 3, 4, 2, 7'd0, 1'b0, 1'b0, me, mf, mb);
        chk_results(1, "p3_zero", 0, 12, 1, 0);
        tick();
        do_run(1, 3, 4, 4, 7'd0, 1'b1, 1'b0, me, mf, mb);

        // 255 passes of all-mismatch: count saturates at 255.
        do_run(2, 255, 1, 3, 7'd0, 1'b0, 1'b0, me, mf, mb);
        chk_results(2, "sat", 0, 255, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
